// File: rtl/stream_pkg.sv
//------------------------------------------------------------------------------
// stream_pkg -- shared helpers and types for the narrowing stream path.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package stream_pkg;

  function automatic int ratio(int win, int wout);
    return (wout > 0) ? (win / wout) : 0;
  endfunction

  // Never returns 0 so index registers keep at least one bit.
  function automatic int idx_width(int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  typedef struct packed {
    logic valid;
    logic ready;
  } hs_flags_t;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } ds_state_e;

endpackage

`default_nettype wire

// File: rtl/stream_downsizer.sv
//------------------------------------------------------------------------------
// stream_downsizer -- splits each wide word into WIDTH_IN/WIDTH_OUT beats, LSB lane first.
// Optional STREAM_DOWNSIZER_LAST_EN adds us_last/ds_last packet framing.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stream_downsizer
  import stream_pkg::*;
#(
  parameter int WIDTH_IN  = 512,
  parameter int WIDTH_OUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 us_valid,
  input  logic [WIDTH_IN-1:0]  us_data,
  output logic                 us_ready,
`ifdef STREAM_DOWNSIZER_LAST_EN
  input  logic                 us_last,
  output logic                 ds_last,
`endif
  output logic                 ds_valid,
  output logic [WIDTH_OUT-1:0] ds_data,
  input  logic                 ds_ready
);

  localparam int RATIO = ratio(WIDTH_IN, WIDTH_OUT);
  localparam int IDXW  = idx_width(RATIO);
  localparam logic [IDXW-1:0] c_IDX_LAST = IDXW'(RATIO - 1);

  generate
    if (WIDTH_OUT <= 0 || RATIO < 2 || (RATIO * WIDTH_OUT) != WIDTH_IN) begin : g_bad_cfg
      $error("stream_downsizer: WIDTH_OUT must divide WIDTH_IN with a ratio of at least 2");
    end
  endgenerate

  ds_state_e           r_state;
  ds_state_e           w_state_nxt;
  logic [IDXW-1:0]     r_idx;
  logic [IDXW-1:0]     w_idx_nxt;
  logic [WIDTH_IN-1:0] r_buf;
  logic [WIDTH_IN-1:0] w_buf_nxt;

  logic      w_full;
  logic      w_last_beat;
  logic      w_us_fire;
  logic      w_ds_fire;
  hs_flags_t w_us_hs;
  hs_flags_t w_ds_hs;

  assign w_full      = (r_state == ST_DRAIN);
  assign w_last_beat = w_full && (r_idx == c_IDX_LAST);

  // Refill only when empty or while the final beat leaves; no path from us_valid.
  assign us_ready = !w_full || (w_last_beat && ds_ready);
  assign ds_valid = w_full;
  assign ds_data  = r_buf[int'(r_idx) * WIDTH_OUT +: WIDTH_OUT];

  assign w_us_hs   = '{valid: us_valid, ready: us_ready};
  assign w_ds_hs   = '{valid: ds_valid, ready: ds_ready};
  assign w_us_fire = w_us_hs.valid && w_us_hs.ready;
  assign w_ds_fire = w_ds_hs.valid && w_ds_hs.ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_buf_nxt   = r_buf;
    if (w_us_fire) begin
      w_state_nxt = ST_DRAIN;
      w_idx_nxt   = '0;
      w_buf_nxt   = us_data;
    end else if (w_ds_fire) begin
      if (w_last_beat) begin
        w_state_nxt = ST_EMPTY;
        w_idx_nxt   = '0;
      end else begin
        w_idx_nxt   = r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_idx   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

`ifdef STREAM_DOWNSIZER_LAST_EN
  logic r_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 1'b0;
    end else if (w_us_fire) begin
      r_last <= us_last;
    end
  end

  assign ds_last = w_last_beat && r_last;
`endif

endmodule

`default_nettype wire
